hic_q14: RTL and testbench
==========================

// Module: hic_q14
// PURPOSE
//  8-bit loadable up/down counter register with mode echo and a tri-state bus port.
//  The 2-bit mode selects per clock: hold, count up, count down or parallel load.
//  cin gates the count step, and cout flags terminal count (carry/borrow) for cascading.
//  The register value is always on fout; it is also driven onto the shared bus fio when oe is high.
// PARAMETERS
//  WIDTH  8  data width of pin, fout and fio (all arithmetic is modulo 2**WIDTH)
// PORTS
//  clk   in     1      single clock, rising-edge active
//  rst   in     1      synchronous, active-high reset (sampled on clk rising edge)
//  cin   in     1      count enable / carry-in; step size for count modes
//  m     in     2      mode: 00 hold, 01 count up, 10 count down, 11 load pin
//  pin   in     WIDTH  parallel load data
//  cout  out    1      terminal-count carry/borrow (combinational)
//  fout  out    WIDTH  counter register value
//  mo    out    2      registered copy of m (mode last applied)
//  oe    out    1      bus output enable (registered)
//  fio   inout  WIDTH  tri-state bus; carries fout when oe=1, high-Z when oe=0
// BEHAVIOUR
//  - Single clock; reset is synchronous and active-high.
//  - All state updates on rising clk. rst has priority over every mode.
//  - Reset values: fout=0, mo=2'b00, oe=0, fio=high-Z, cout=0 (fout=0 with mo=00).
//  - Register update per edge, when rst=0:
//      m=00: fout holds.
//      m=01: fout <= fout + cin; 8'hFF+1 wraps to 8'h00.
//      m=10: fout <= fout - cin; 8'h00-1 wraps to 8'hFF.
//      m=11: fout <= pin (cin ignored).
//  - Latency: one clock. The new fout is visible after the edge that sampled m, cin and pin.
//  - mo <= m every edge; oe <= (m != 2'b00) every edge.
//  - oe=0 after hold cycles and after reset.
//  - cout is combinational from the current mo, fout and cin:
//      mo=01: cout = cin & (fout==8'hFF)
//      mo=10: cout = cin & (fout==8'h00)
//      mo=00 or mo=11: cout = 0
//  - cout therefore asserts in the cycle before a wrap, so an upstream stage can chain it.
//  - fio = oe ? fout : 'z. The block never samples fio.
//  - Mode changes take effect on the next edge; no settling cycles are required.
//  - Every mode may follow any other back-to-back.
//  - Reset asserted mid-count clears on that edge; counting resumes from 0 on the first edge after rst drops.
//  - pin changes while m!=11 have no effect.
//  - X/Z on m: the implementation must not latch; the default branch is hold.
// TESTING
//  1. rst=1 for one edge, m=11, pin=15 -> fout=0, mo=00, oe=0, fio=Z.
//     Release rst -> next edge fout=15, mo=11, oe=1, fio=15.
//  2. Load random pin values each edge (e.g. 8'hA5, 8'h3C, 8'hFF) with m=11
//     -> fout follows pin one edge later; cout=0 throughout.
//  3. fout=15, m=01, cin=1, 5 edges -> fout 16..20, cout=0.
//     Then cin=0 -> fout holds at 20.
//  4. Load 8'hFE, m=01, cin=1 -> fout FF with cout=1, then 00 with cout=0 (wrap).
//     Load 8'h01, m=10 -> fout 00 with cout=1, then FF (borrow wrap).
//  5. fout=20, m=10, cin=1, 5 edges -> 19..15.
//     Then m=00, 5 edges -> fout=15 steady, mo=00, oe=0, fio=Z, cout=0.
//  6. rst=1 asserted mid-count (m=01, fout=100) -> next edge fout=0, oe=0.
//     Release rst -> count resumes 1, 2, ...

Source files
------------

// File: rtl/hic_q14.sv
// hic_q14: loadable up/down counter with mode echo, terminal-count carry and tri-state bus port
module hic_q14 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cin,
  input  logic [1:0]       m,
  input  logic [WIDTH-1:0] pin,
  output logic             cout,
  output logic [WIDTH-1:0] fout,
  output logic [1:0]       mo,
  output logic             oe,
  inout  wire  [WIDTH-1:0] fio
);
  logic [WIDTH-1:0] nxt;
  always_comb begin
    nxt = fout;
    case (m)
      2'b01:   nxt = fout + WIDTH'(cin);
      2'b10:   nxt = fout - WIDTH'(cin);
      2'b11:   nxt = pin;
      default: nxt = fout;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fout <= '0;
      mo   <= 2'b00;
      oe   <= 1'b0;
    end else begin
      fout <= nxt;
      mo   <= m;
      oe   <= m != 2'b00;
    end
  end
  assign cout = mo == 2'b01 ? cin & (&fout) : mo == 2'b10 ? cin & ~(|fout) : 1'b0;
  assign fio  = oe ? fout : 'z;
endmodule

// File: tb/tb_hic_q14.sv
// tb_hic_q14: directed vector table plus randomized run against an arithmetic reference model
module tb_hic_q14;
  logic       clk = 0;
  logic       rst, cin;
  logic [1:0] m;
  logic [7:0] pin;
  logic       cout, oe;
  logic [7:0] fout;
  logic [1:0] mo;
  wire  [7:0] fio;
  int         nvec = 0, nbad = 0;

  hic_q14 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cin(cin), .m(m), .pin(pin),
    .cout(cout), .fout(fout), .mo(mo), .oe(oe), .fio(fio)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [1:0] m;
    logic       c;
    logic [7:0] p;
    logic [7:0] f;
    logic [1:0] o;
    logic       e;
    logic       co;
  } vec_t;
  vec_t tv[$];

  task automatic step(input logic r, input logic [1:0] mm, input logic c, input logic [7:0] p);
    @(negedge clk);
    rst = r; m = mm; cin = c; pin = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] ef, input logic [1:0] emo,
                     input logic eoe, input logic eco);
    logic [7:0] efio;
    efio = eoe ? ef : 8'bz;
    nvec++;
    if (fout !== ef || mo !== emo || oe !== eoe || cout !== eco || fio !== efio) begin
      nbad++;
      $display("FAIL %s: got fout=%h mo=%b oe=%b cout=%b fio=%h, want fout=%h mo=%b oe=%b cout=%b fio=%h",
               name, fout, mo, oe, cout, fio, ef, emo, eoe, eco, efio);
    end
  endtask

  initial begin
    int f, mm, c, r, p, em, eo;
    rst = 1; m = 0; cin = 0; pin = 0;
    tv.push_back('{1'b1, 2'b11, 1'b0, 8'd15,   8'h00, 2'b00, 1'b0, 1'b0});
    tv.push_back('{1'b0, 2'b11, 1'b0, 8'd15,   8'h0F, 2'b11, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b11, 1'b0, 8'hA5,   8'hA5, 2'b11, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b11, 1'b1, 8'h3C,   8'h3C, 2'b11, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b11, 1'b1, 8'hFF,   8'hFF, 2'b11, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b11, 1'b1, 8'h0F,   8'h0F, 2'b11, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++)
      tv.push_back('{1'b0, 2'b01, 1'b1, 8'h55, 8'(16 + i), 2'b01, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b01, 1'b0, 8'h00,   8'h14, 2'b01, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b11, 1'b1, 8'hFE,   8'hFE, 2'b11, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b01, 1'b1, 8'h00,   8'hFF, 2'b01, 1'b1, 1'b1});
    tv.push_back('{1'b0, 2'b01, 1'b1, 8'h00,   8'h00, 2'b01, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b11, 1'b1, 8'h01,   8'h01, 2'b11, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b10, 1'b1, 8'h00,   8'h00, 2'b10, 1'b1, 1'b1});
    tv.push_back('{1'b0, 2'b10, 1'b1, 8'h00,   8'hFF, 2'b10, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b11, 1'b0, 8'd20,   8'd20, 2'b11, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++)
      tv.push_back('{1'b0, 2'b10, 1'b1, 8'hAA, 8'(19 - i), 2'b10, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++)
      tv.push_back('{1'b0, 2'b00, 1'b1, 8'h99, 8'd15, 2'b00, 1'b0, 1'b0});
    tv.push_back('{1'b0, 2'b11, 1'b0, 8'd100,  8'd100, 2'b11, 1'b1, 1'b0});
    tv.push_back('{1'b1, 2'b01, 1'b1, 8'h00,   8'h00, 2'b00, 1'b0, 1'b0});
    tv.push_back('{1'b0, 2'b01, 1'b1, 8'h00,   8'h01, 2'b01, 1'b1, 1'b0});
    tv.push_back('{1'b0, 2'b01, 1'b1, 8'h00,   8'h02, 2'b01, 1'b1, 1'b0});
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].m, tv[i].c, tv[i].p);
      chk($sformatf("vec%0d", i), tv[i].f, tv[i].o, tv[i].e, tv[i].co);
    end
    f = 2; em = 1; eo = 1;
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      mm = $urandom_range(0, 3);
      c  = $urandom_range(0, 1);
      p  = (i % 7 == 0) ? (($urandom_range(0, 1) == 1) ? 255 : 1) : $urandom_range(0, 255);
      step(r[0], mm[1:0], c[0], p[7:0]);
      if (r) begin
        f = 0; em = 0; eo = 0;
      end else begin
        if (mm == 1) f = (f + c) % 256;
        else if (mm == 2) f = (f - c + 256) % 256;
        else if (mm == 3) f = p;
        em = mm;
        eo = (mm != 0);
      end
      chk($sformatf("rnd%0d", i), f[7:0], em[1:0], eo[0],
          c == 1 && ((em == 1 && f == 255) || (em == 2 && f == 0)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
